// File: rtl/regfile_dump_if.sv
// rtl/regfile_dump_if.sv - register-file debug read port plus UART TX byte stream
//
// Purpose : bundles the two buses regfile_dump talks over.
//   rf_adr   : debug read address into the register file
//   rf_dout  : combinational read data for rf_adr (x0 reads 0)
//   tx_data  : byte presented to the UART TX FIFO
//   tx_valid : tx_data is valid
//   tx_ready : UART TX accepts the byte this cycle
// Modports:
//   master : the dump engine (drives rf_adr, tx_data, tx_valid)
//   slave  : register file + UART side (drives rf_dout, tx_ready)

interface regfile_dump_if #(
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rf_adr;
   logic [31:0]       rf_dout;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output rf_adr,
      input  rf_dout,
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  rf_adr,
      output rf_dout,
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - register-file debug dump engine streaming bytes to UART TX
//
// Purpose : on a start pulse, reads registers 0..NREGS-1 through the debug
//           read port, freezes each 32-bit value, and sends it little-endian,
//           one byte per accepted handshake.
// Ports   :
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset; aborts a dump immediately
//   start  : begin a dump (only honoured while idle)
//   busy   : dump in progress (LOAD, SEND or DONE)
//   done   : one-cycle pulse after the final byte was accepted
//   bus    : regfile_dump_if.master (rf_adr/rf_dout, tx_data/tx_valid/tx_ready)
// Config  :
//   REGDUMP_IDX_EN : when defined, each record is prefixed with an index byte
//                    holding the register address (5 bytes per record).

module regfile_dump #(
   parameter int NREGS  = 32,
   parameter int ADDR_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   regfile_dump_if.master   bus
);

`ifdef REGDUMP_IDX_EN
   localparam logic [2:0] LAST_BYTE = 3'd4;
`else
   localparam logic [2:0] LAST_BYTE = 3'd3;
`endif
   localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(NREGS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state_q, state_nxt;
   logic [ADDR_W-1:0] adr_q,   adr_nxt;
   logic [31:0]       word_q,  word_nxt;
   logic [2:0]        cnt_q,   cnt_nxt;
   logic              xfer;

   // tx_valid is a pure decode of the state register, so it drops together
   // with the asynchronous reset and can never fall without a transfer.
   assign bus.tx_valid = (state_q == SEND);
   assign xfer         = (state_q == SEND) && bus.tx_ready;
   assign bus.rf_adr   = adr_q;
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);

   // Byte selection reads only the frozen word and the byte counter, both of
   // which hold while a byte is stalled, so tx_data stays stable under
   // backpressure. Reset values of word/counter make tx_data reset to 0.
   always_comb begin
      bus.tx_data = 8'h00;
`ifdef REGDUMP_IDX_EN
      case (cnt_q)
         3'd0:    bus.tx_data = 8'(adr_q);
         3'd1:    bus.tx_data = word_q[7:0];
         3'd2:    bus.tx_data = word_q[15:8];
         3'd3:    bus.tx_data = word_q[23:16];
         3'd4:    bus.tx_data = word_q[31:24];
         default: bus.tx_data = 8'h00;
      endcase
`else
      case (cnt_q[1:0])
         2'd0:    bus.tx_data = word_q[7:0];
         2'd1:    bus.tx_data = word_q[15:8];
         2'd2:    bus.tx_data = word_q[23:16];
         default: bus.tx_data = word_q[31:24];
      endcase
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         adr_q   <= '0;
         word_q  <= 32'h0;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_nxt;
         adr_q   <= adr_nxt;
         word_q  <= word_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      adr_nxt   = adr_q;
      word_nxt  = word_q;
      cnt_nxt   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               adr_nxt   = '0;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            // Snapshot here so a register write during SEND cannot tear a record.
            word_nxt  = bus.rf_dout;
            cnt_nxt   = 3'd0;
            state_nxt = SEND;
         end
         SEND: begin
            if (xfer) begin
               if (cnt_q != LAST_BYTE) begin
                  cnt_nxt = cnt_q + 3'd1;
               end else if (adr_q != LAST_ADR) begin
                  adr_nxt   = adr_q + 1'b1;
                  state_nxt = LOAD;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
